spmm_sched: RTL and testbench
=============================

// Module: spmm_sched
// PURPOSE
//  Control sequencer for the SpMM datapath (RHS buffer, N-column PE array, output drain).
//  Owns the external ready/start handshakes and drives the datapath strobes (RHS block write, PE start, output block select).
//  Adds weight-stationary reuse: a loaded RHS may serve several LHS matrices without reload.
//  Sits between the SpMM top-level ports and the RHS buffer / PE array / output mux. No data passes through it.
// PARAMETERS
//  N       16  matrix dimension; multiple of 4, >= 8
//  PE_LAT  2   cycles from PE start to first valid PE result (multiplier reg + reduction)
// PORTS
//  clock          in   1            single clock, rising edge
//  reset          in   1            synchronous, active-high
//  rhs_start      in   1            RHS load request, honoured only while rhs_ready=1
//  lhs_start      in   1            LHS issue request
//  lhs_ws         in   1            with lhs_start: reuse the resident RHS (weight-stationary)
//  out_start      in   1            consumer begins draining, honoured only while out_ready=1
//  rhs_ready      out  1            scheduler accepts rhs_start
//  lhs_ready_ns   out  1            LHS accepted against a freshly loaded RHS
//  lhs_ready_ws   out  1            LHS accepted against the resident, already-used RHS
//  out_ready      out  1            result complete, waiting for out_start
//  rhs_wr_en      out  1            RHS buffer writes 4 rows this cycle
//  rhs_wr_blk     out  clog2(N/4)   row block index (rows 4*blk..4*blk+3)
//  pe_start       out  1            one-cycle pulse that starts the PE array
//  out_vld        out  1            out_data carries block out_blk
//  out_blk        out  clog2(N/4)   output row block index
//  busy           out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rhs_valid=0; rhs_fresh=0; all counters=0; every output=0.
//  Reset mid-operation: same values on the next edge; any partially loaded RHS is invalidated (rhs_valid=0).
//  States: IDLE, LOAD, COMPUTE, WAIT_OUT, DRAIN.
//  rhs_ready    = (IDLE).
//  lhs_ready_ns = (IDLE & rhs_valid & rhs_fresh).
//  lhs_ready_ws = (IDLE & rhs_valid & !rhs_fresh).
//  IDLE priority:
//   1. lhs_start=1 with a matching ready (lhs_ws=0 needs ns; lhs_ws=1 needs ws or ns) -> COMPUTE.
//      pe_start=1 that same cycle; rhs_fresh<=0.
//   2. Else rhs_start=1 -> LOAD; blk<=0; rhs_valid<=0.
//   Any other start is ignored, with no state change.
//  LOAD: rhs_wr_en=1, rhs_wr_blk=blk for N/4 consecutive cycles.
//   On the last block -> IDLE; rhs_valid<=1; rhs_fresh<=1. rhs_start/lhs_start are ignored.
//  COMPUTE: cnt counts 0..N+PE_LAT-1, then -> WAIT_OUT. Latency from pe_start to out_ready is N+PE_LAT cycles.
//  WAIT_OUT: out_ready=1 until out_start=1, then -> DRAIN with blk<=0.
//   out_start arrives in the same cycle that out_ready rises -> accepted.
//  DRAIN: out_vld=1, out_blk=blk for N/4 cycles; then -> IDLE with rhs_valid retained.
//   The first output block appears the cycle after out_start is sampled.
//  Counter widths: cnt is clog2(N+PE_LAT+1); blk is clog2(N/4). Counters reset to 0 on every state entry and never wrap inside a state.
//  Strobes are 0 in every state not listed above. pe_start is never high for more than 1 cycle.
// STRUCTURE
//  Shared package spmm_pkg: sched_state_t enum, the N/W defaults, and a BLK_W = clog2(N/4) localparam.
//  One sub-module, blk_counter: load/clear, terminal count at a parameter.
//   Instantiated twice: LOAD/DRAIN block index and COMPUTE cycle count.
//  Next-state logic is combinational; state and flags are registered.
// TESTING (N=16, PE_LAT=2)
//  1. Reset, then rhs_start@c0.
//     -> rhs_wr_en c1..c4, rhs_wr_blk 0,1,2,3.
//     -> lhs_ready_ns=1 from c5; lhs_ready_ws=0.
//  2. lhs_start (lhs_ws=0) @c6.
//     -> pe_start pulse at c6.
//     -> out_ready=1 at c24 (18 cycles later).
//     -> out_start@c24 gives out_vld c25..c28, out_blk 0..3, then IDLE.
//  3. After test 2: lhs_ready_ns=0 and lhs_ready_ws=1.
//     -> lhs_start with lhs_ws=1: accepted, no LOAD cycles.
//     -> lhs_start with lhs_ws=0: ignored, state stays IDLE.
//  4. rhs_start and lhs_start both high in IDLE with the RHS loaded.
//     -> lhs wins and enters COMPUTE. rhs_start is dropped; rhs_ready=0 until IDLE returns.
//  5. reset asserted during LOAD blk=2 or during DRAIN blk=1.
//     -> Next cycle: all outputs 0 and rhs_valid=0.
//     -> A later lhs_start with lhs_ws=1 is ignored.
//  6. Hold out_start low for 10 cycles in WAIT_OUT.
//     -> out_ready stays 1 and out_vld stays 0. rhs_start/lhs_start are ignored throughout.

Source files
------------

// File: rtl/spmm_pkg.sv
// SpMM scheduler shared types and default sizing.
// Imported by the scheduler top and its counter sub-module.
package spmm_pkg;

  localparam int N_DEF      = 16;
  localparam int PE_LAT_DEF = 2;
  localparam int BLK_W      = $clog2(N_DEF / 4);
  localparam int CNT_W      = $clog2(N_DEF + PE_LAT_DEF + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_WAIT_OUT,
    S_DRAIN
  } sched_state_t;

endpackage

// File: rtl/spmm_sched_blk_counter.sv
// Clearable up-counter that saturates at a terminal count.
// Used for the block index and the compute cycle count.
module blk_counter
  import spmm_pkg::*;
#(
  parameter int W  = BLK_W,
  parameter int TC = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(TC));

endmodule

// File: rtl/spmm_sched.sv
// SpMM control sequencer: RHS load, PE issue, output drain,
// with weight-stationary reuse of a resident RHS.
module spmm_sched
  import spmm_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_rhs_start,
  input  logic                     i_lhs_start,
  input  logic                     i_lhs_ws,
  input  logic                     i_out_start,
  output logic                     o_rhs_ready,
  output logic                     o_lhs_ready_ns,
  output logic                     o_lhs_ready_ws,
  output logic                     o_out_ready,
  output logic                     o_rhs_wr_en,
  output logic [$clog2(N/4)-1:0]   o_rhs_wr_blk,
  output logic                     o_pe_start,
  output logic                     o_out_vld,
  output logic [$clog2(N/4)-1:0]   o_out_blk,
  output logic                     o_busy
);

  localparam int BW = $clog2(N / 4);
  localparam int CW = $clog2(N + PE_LAT + 1);

  sched_state_t r_state, w_next;
  logic r_rhs_valid, r_rhs_fresh;

  logic [BW-1:0] w_blk;
  logic [CW-1:0] w_cnt;
  logic w_blk_tc, w_cnt_tc;
  logic w_idle, w_ns, w_ws, w_lhs_ok, w_blk_run, w_cmp_run;

  assign w_idle    = (r_state == S_IDLE);
  assign w_ns      = w_idle & r_rhs_valid & r_rhs_fresh;
  assign w_ws      = w_idle & r_rhs_valid & ~r_rhs_fresh;
  assign w_lhs_ok  = i_lhs_start & (i_lhs_ws ? (w_ws | w_ns) : w_ns);
  assign w_blk_run = (r_state == S_LOAD) | (r_state == S_DRAIN);
  assign w_cmp_run = (r_state == S_COMPUTE);

  blk_counter #(.W(BW), .TC(N / 4 - 1)) u_blk (
    .i_clk (i_clock),
    .i_rst (i_reset),
    .i_clr (~w_blk_run),
    .i_en  (w_blk_run),
    .o_cnt (w_blk),
    .o_tc  (w_blk_tc)
  );

  // The pe_start cycle is cycle 0 of the PE latency, so COMPUTE
  // itself lasts N+PE_LAT-1 cycles before out_ready rises.
  blk_counter #(.W(CW), .TC(N + PE_LAT - 2)) u_cnt (
    .i_clk (i_clock),
    .i_rst (i_reset),
    .i_clr (~w_cmp_run),
    .i_en  (w_cmp_run),
    .o_cnt (w_cnt),
    .o_tc  (w_cnt_tc)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rhs_valid <= 1'b0;
      r_rhs_fresh <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_lhs_ok) begin
        r_rhs_fresh <= 1'b0;
      end else if (w_idle && i_rhs_start) begin
        r_rhs_valid <= 1'b0;
      end else if (r_state == S_LOAD && w_blk_tc) begin
        r_rhs_valid <= 1'b1;
        r_rhs_fresh <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_lhs_ok)         w_next = S_COMPUTE;
        else if (i_rhs_start) w_next = S_LOAD;
      end
      S_LOAD:     if (w_blk_tc)    w_next = S_IDLE;
      S_COMPUTE:  if (w_cnt_tc)    w_next = S_WAIT_OUT;
      S_WAIT_OUT: if (i_out_start) w_next = S_DRAIN;
      S_DRAIN:    if (w_blk_tc)    w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    o_rhs_ready    = 1'b0;
    o_lhs_ready_ns = 1'b0;
    o_lhs_ready_ws = 1'b0;
    o_out_ready    = 1'b0;
    o_rhs_wr_en    = 1'b0;
    o_rhs_wr_blk   = '0;
    o_pe_start     = 1'b0;
    o_out_vld      = 1'b0;
    o_out_blk      = '0;
    o_busy         = 1'b0;
    if (!i_reset) begin
      o_rhs_ready    = w_idle;
      o_lhs_ready_ns = w_ns;
      o_lhs_ready_ws = w_ws;
      o_busy         = ~w_idle;
      case (r_state)
        S_IDLE: o_pe_start = w_lhs_ok;
        S_LOAD: begin
          o_rhs_wr_en  = 1'b1;
          o_rhs_wr_blk = w_blk;
        end
        S_WAIT_OUT: o_out_ready = 1'b1;
        S_DRAIN: begin
          o_out_vld = 1'b1;
          o_out_blk = w_blk;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spmm_sched.sv
// Directed bench for spmm_sched at N=16, PE_LAT=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_spmm_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rhs_start = 0, lhs_start = 0, lhs_ws = 0, out_start = 0;
  logic rhs_ready, ns, ws, out_ready, wr_en, pe_start, out_vld, busy;
  logic [1:0] wr_blk, out_blk;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spmm_sched dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_rhs_start    (rhs_start),
    .i_lhs_start    (lhs_start),
    .i_lhs_ws       (lhs_ws),
    .i_out_start    (out_start),
    .o_rhs_ready    (rhs_ready),
    .o_lhs_ready_ns (ns),
    .o_lhs_ready_ws (ws),
    .o_out_ready    (out_ready),
    .o_rhs_wr_en    (wr_en),
    .o_rhs_wr_blk   (wr_blk),
    .o_pe_start     (pe_start),
    .o_out_vld      (out_vld),
    .o_out_blk      (out_blk),
    .o_busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, rhs_ready, ns, ws, out_ready, wr_en, wr_blk,
            pe_start, out_vld, out_blk, busy};
  endfunction

  // Run COMPUTE from the cycle after pe_start up to WAIT_OUT.
  task automatic run_compute(input string tag);
    for (int i = 0; i < 17; i++) begin
      chk({tag, "_cmp_rdy"}, {31'd0, out_ready}, 32'd0);
      step();
    end
    chk({tag, "_rdy"}, {31'd0, out_ready}, 32'd1);
  endtask

  task automatic drain(input string tag);
    out_start = 1;
    step();
    out_start = 0;
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_vld"}, {31'd0, out_vld}, 32'd1);
      chk({tag, "_blk"}, {30'd0, out_blk}, b);
      step();
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    step();
    chk("rst_hold", outs(), 32'd0);
    rst = 0;
    step();
    // c0: idle after reset, request RHS load
    chk("rst_rdy", {31'd0, rhs_ready}, 32'd1);
    chk("rst_ns", {31'd0, ns}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rhs_start = 1;
    step();
    rhs_start = 0;
    for (int b = 0; b < 4; b++) begin
      chk("ld_en", {31'd0, wr_en}, 32'd1);
      chk("ld_blk", {30'd0, wr_blk}, b);
      step();
    end
    // c5
    chk("ld_done_en", {31'd0, wr_en}, 32'd0);
    chk("ns_c5", {31'd0, ns}, 32'd1);
    chk("ws_c5", {31'd0, ws}, 32'd0);
    step();
    // c6: issue against fresh RHS
    lhs_start = 1;
    lhs_ws = 0;
    #1;
    chk("pe_c6", {31'd0, pe_start}, 32'd1);
    step();
    lhs_start = 0;
    chk("pe_c7", {31'd0, pe_start}, 32'd0);
    chk("busy_c7", {31'd0, busy}, 32'd1);
    run_compute("t2");
    drain("t2");
    chk("t3_ns", {31'd0, ns}, 32'd0);
    chk("t3_ws", {31'd0, ws}, 32'd1);

    // non-WS issue against used RHS is ignored
    lhs_start = 1;
    lhs_ws = 0;
    #1;
    chk("t3_ns_pe", {31'd0, pe_start}, 32'd0);
    step();
    chk("t3_ns_busy", {31'd0, busy}, 32'd0);
    lhs_ws = 1;
    #1;
    chk("t3_ws_pe", {31'd0, pe_start}, 32'd1);
    step();
    lhs_start = 0;
    chk("t3_ws_noload", {31'd0, wr_en}, 32'd0);
    chk("t3_ws_busy", {31'd0, busy}, 32'd1);
    run_compute("t3");

    // hold out_start low; starts must be ignored
    rhs_start = 1;
    lhs_start = 1;
    for (int i = 0; i < 10; i++) begin
      chk("t6_rdy", {31'd0, out_ready}, 32'd1);
      chk("t6_vld", {31'd0, out_vld}, 32'd0);
      chk("t6_wr", {31'd0, wr_en}, 32'd0);
      chk("t6_pe", {31'd0, pe_start}, 32'd0);
      step();
    end
    rhs_start = 0;
    lhs_start = 0;
    drain("t6");

    // lhs beats rhs in IDLE
    rhs_start = 1;
    lhs_start = 1;
    lhs_ws = 1;
    #1;
    chk("t4_pe", {31'd0, pe_start}, 32'd1);
    step();
    rhs_start = 0;
    lhs_start = 0;
    chk("t4_rhs_rdy", {31'd0, rhs_ready}, 32'd0);
    chk("t4_no_load", {31'd0, wr_en}, 32'd0);
    run_compute("t4");
    chk("t4_rhs_rdy_w", {31'd0, rhs_ready}, 32'd0);

    // reset during DRAIN blk=1
    out_start = 1;
    step();
    out_start = 0;
    step();
    chk("t5d_blk", {30'd0, out_blk}, 32'd1);
    rst = 1;
    step();
    chk("t5d_outs", outs(), 32'd0);
    rst = 0;
    #1;
    chk("t5d_ws", {31'd0, ws}, 32'd0);
    chk("t5d_rdy", {31'd0, rhs_ready}, 32'd1);
    lhs_start = 1;
    lhs_ws = 1;
    #1;
    chk("t5d_pe", {31'd0, pe_start}, 32'd0);
    step();
    lhs_start = 0;
    chk("t5d_busy", {31'd0, busy}, 32'd0);

    // reset during LOAD blk=2
    rhs_start = 1;
    step();
    rhs_start = 0;
    step();
    step();
    chk("t5l_blk", {30'd0, wr_blk}, 32'd2);
    rst = 1;
    step();
    chk("t5l_outs", outs(), 32'd0);
    rst = 0;
    #1;
    chk("t5l_ns", {31'd0, ns}, 32'd0);
    chk("t5l_ws", {31'd0, ws}, 32'd0);
    lhs_start = 1;
    lhs_ws = 1;
    #1;
    chk("t5l_pe", {31'd0, pe_start}, 32'd0);
    step();
    lhs_start = 0;
    chk("t5l_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
